// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset vector,
// immediate-flag position, FSM encoding and the bubble constant.
package fetch_stage_pkg;

    localparam int unsigned DEF_ADDR_W  = 32;
    localparam int unsigned DEF_INSTR_W = 16;
    localparam int unsigned DEF_IMM_BIT = 0;
    localparam logic [31:0] DEF_RST_VEC = 32'h0000_0000;

    // An empty IF/ID slot carries an all-zero instruction word
    localparam logic [DEF_INSTR_W-1:0] BUBBLE_INSTR = '0;

    typedef enum logic [1:0] {
        ST_RST_HI    = 2'd0,
        ST_RST_LO    = 2'd1,
        ST_FETCH     = 2'd2,
        ST_FETCH_IMM = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: pipeline control in, instruction-memory port, IF/ID outputs.
// master = fetch stage, slave = surrounding pipeline / memory.
interface fetch_stage_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 16
);
    logic               stall;
    logic               flush;
    logic [ADDR_W-1:0]  branch_target;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] if_id_instr;
    logic [INSTR_W-1:0] if_id_imm;
    logic [ADDR_W-1:0]  if_id_pc_next;
    logic               if_id_valid;

    modport master (
        input  stall, flush, branch_target, imem_data,
        output imem_addr, pc, if_id_instr, if_id_imm, if_id_pc_next, if_id_valid
    );

    modport slave (
        output stall, flush, branch_target, imem_data,
        input  imem_addr, pc, if_id_instr, if_id_imm, if_id_pc_next, if_id_valid
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. bubble wins over load; with neither it holds.
module if_id_reg #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               bubble,
    input  logic [INSTR_W-1:0] instr_in,
    input  logic [INSTR_W-1:0] imm_in,
    input  logic [ADDR_W-1:0]  pc_next_in,
    output logic [INSTR_W-1:0] instr,
    output logic [INSTR_W-1:0] imm,
    output logic [ADDR_W-1:0]  pc_next,
    output logic               valid
);

    // Register the decoded slot, clearing it on bubble or reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr   <= '0;
            imm     <= '0;
            pc_next <= '0;
            valid   <= 1'b0;
        end else if (bubble) begin
            instr   <= '0;
            imm     <= '0;
            pc_next <= '0;
            valid   <= 1'b0;
        end else if (load) begin
            instr   <= instr_in;
            imm     <= imm_in;
            pc_next <= pc_next_in;
            valid   <= 1'b1;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, loads it from the reset vector, and
// assembles one- or two-word instructions into the IF/ID register.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   ST_RST_HI    | read reset-vector high word into pc[31:16]
//   ST_RST_LO    | read reset-vector low word into pc[15:0]
//   ST_FETCH     | fetch first word of an instruction at pc
//   ST_FETCH_IMM | fetch immediate word at pc for the held instruction
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int unsigned       ADDR_W  = DEF_ADDR_W,
    parameter int unsigned       INSTR_W = DEF_INSTR_W,
    parameter int unsigned       IMM_BIT = DEF_IMM_BIT,
    parameter logic [ADDR_W-1:0] RST_VEC = DEF_RST_VEC
) (
    input logic          clk,
    input logic          rst,
    fetch_stage_if.master bus
);

    // The reset vector is split into exactly two memory words
    localparam int unsigned HI_LSB = ADDR_W - INSTR_W;

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [INSTR_W-1:0] hold_q, hold_d;
    logic [ADDR_W-1:0]  pc_inc;
    logic               ld, bub;
    logic [INSTR_W-1:0] instr_d, imm_d;

    assign pc_inc = pc_q + ADDR_W'(1);
    assign bus.pc = pc_q;

    // State, PC and held first word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RST_HI;
            pc_q    <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            hold_q  <= hold_d;
        end
    end

    // Next-state, memory address and IF/ID controls; flush beats stall
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_d        = hold_q;
        ld            = 1'b0;
        bub           = 1'b0;
        instr_d       = bus.imem_data;
        imm_d         = '0;
        bus.imem_addr = pc_q;
        case (state_q)
            ST_RST_HI: begin
                bus.imem_addr              = RST_VEC;
                pc_d[ADDR_W-1:HI_LSB]      = bus.imem_data;
                state_d                    = ST_RST_LO;
            end
            ST_RST_LO: begin
                bus.imem_addr              = RST_VEC + ADDR_W'(1);
                pc_d[INSTR_W-1:0]          = bus.imem_data;
                state_d                    = ST_FETCH;
            end
            ST_FETCH: begin
                if (bus.flush) begin
                    pc_d    = bus.branch_target;
                    hold_d  = '0;
                    bub     = 1'b1;
                    state_d = ST_FETCH;
                end else if (!bus.stall) begin
                    pc_d = pc_inc;
                    if (bus.imem_data[IMM_BIT]) begin
                        hold_d  = bus.imem_data;
                        bub     = 1'b1;
                        state_d = ST_FETCH_IMM;
                    end else begin
                        ld = 1'b1;
                    end
                end
            end
            ST_FETCH_IMM: begin
                if (bus.flush) begin
                    pc_d    = bus.branch_target;
                    hold_d  = '0;
                    bub     = 1'b1;
                    state_d = ST_FETCH;
                end else if (!bus.stall) begin
                    ld      = 1'b1;
                    instr_d = hold_q;
                    imm_d   = bus.imem_data;
                    pc_d    = pc_inc;
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_RST_HI;
        endcase
    end

    if_id_reg #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_if_id (
        .clk        (clk),
        .rst        (rst),
        .load       (ld),
        .bubble     (bub),
        .instr_in   (instr_d),
        .imm_in     (imm_d),
        .pc_next_in (pc_inc),
        .instr      (bus.if_id_instr),
        .imm        (bus.if_id_imm),
        .pc_next    (bus.if_id_pc_next),
        .valid      (bus.if_id_valid)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reset vector, straight-line, immediate,
// stall, flush+stall in FETCH_IMM, async reset and PC wrap.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    logic [15:0] mem [0:511];

    fetch_stage_if #(.ADDR_W(32), .INSTR_W(16)) bus ();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory answers combinationally; upper address bits alias onto 512 words
    always_comb bus.imem_data = mem[bus.imem_addr[8:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ifid(input string tag, input logic [15:0] instr, input logic [15:0] imm,
                            input logic [31:0] pcn, input logic valid);
        chk({tag, ".instr"},   {16'h0, bus.if_id_instr}, {16'h0, instr});
        chk({tag, ".imm"},     {16'h0, bus.if_id_imm},   {16'h0, imm});
        chk({tag, ".pc_next"}, bus.if_id_pc_next,        pcn);
        chk({tag, ".valid"},   {31'h0, bus.if_id_valid}, {31'h0, valid});
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
        mem[9'h000] = 16'h0000;
        mem[9'h001] = 16'h0020;
        mem[9'h020] = 16'h1230;
        mem[9'h021] = 16'h4560;
        mem[9'h022] = 16'h7001;
        mem[9'h023] = 16'hBEEF;
        mem[9'h024] = 16'h2220;
        mem[9'h025] = 16'h3330;
        mem[9'h026] = 16'h4440;
        mem[9'h027] = 16'h6001;
        mem[9'h028] = 16'hAAAA;
        mem[9'h100] = 16'h8880;
        mem[9'h101] = 16'h9001;
        mem[9'h102] = 16'hCCCC;

        bus.stall         = 1'b0;
        bus.flush         = 1'b0;
        bus.branch_target = 32'h0;
        rst               = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.pc",   bus.pc, 32'h0);
        chk("rst.addr", bus.imem_addr, 32'h0);
        chk_ifid("rst", 16'h0, 16'h0, 32'h0, 1'b0);
        rst = 1'b0;

        // Reset-vector load
        step();
        chk("rv1.addr",  bus.imem_addr, 32'h1);
        chk("rv1.valid", {31'h0, bus.if_id_valid}, 32'h0);
        step();
        chk("rv2.pc",    bus.pc, 32'h20);
        chk("rv2.addr",  bus.imem_addr, 32'h20);
        chk("rv2.valid", {31'h0, bus.if_id_valid}, 32'h0);

        // Straight-line
        step();
        chk_ifid("s1", 16'h1230, 16'h0, 32'h21, 1'b1);
        chk("s1.pc", bus.pc, 32'h21);
        step();
        chk_ifid("s2", 16'h4560, 16'h0, 32'h22, 1'b1);

        // Two-word instruction
        step();
        chk_ifid("imm.bub", 16'h0, 16'h0, 32'h0, 1'b0);
        chk("imm.bub.pc", bus.pc, 32'h23);
        step();
        chk_ifid("imm", 16'h7001, 16'hBEEF, 32'h24, 1'b1);
        chk("imm.pc", bus.pc, 32'h24);
        step();
        chk_ifid("s3", 16'h2220, 16'h0, 32'h25, 1'b1);

        // Stall three edges
        bus.stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("stall.pc",   bus.pc, 32'h25);
            chk("stall.addr", bus.imem_addr, 32'h25);
            chk_ifid("stall", 16'h2220, 16'h0, 32'h25, 1'b1);
        end
        bus.stall = 1'b0;
        step();
        chk_ifid("resume1", 16'h3330, 16'h0, 32'h26, 1'b1);
        step();
        chk_ifid("resume2", 16'h4440, 16'h0, 32'h27, 1'b1);

        // Flush + stall while half-way through a two-word instruction
        step();
        chk_ifid("fl.bub", 16'h0, 16'h0, 32'h0, 1'b0);
        chk("fl.pre.pc", bus.pc, 32'h28);
        bus.flush         = 1'b1;
        bus.stall         = 1'b1;
        bus.branch_target = 32'h100;
        step();
        bus.flush = 1'b0;
        bus.stall = 1'b0;
        chk_ifid("flush", 16'h0, 16'h0, 32'h0, 1'b0);
        chk("flush.pc",   bus.pc, 32'h100);
        chk("flush.addr", bus.imem_addr, 32'h100);
        step();
        chk_ifid("tgt", 16'h8880, 16'h0, 32'h101, 1'b1);

        // Async reset mid FETCH_IMM
        step();
        chk_ifid("ar.bub", 16'h0, 16'h0, 32'h0, 1'b0);
        chk("ar.pre.pc", bus.pc, 32'h102);
        #2;
        rst = 1'b1;
        #1;
        chk("ar.pc",   bus.pc, 32'h0);
        chk("ar.addr", bus.imem_addr, 32'h0);
        chk_ifid("ar", 16'h0, 16'h0, 32'h0, 1'b0);
        mem[9'h000] = 16'hFFFF;
        mem[9'h001] = 16'hFFFF;
        mem[9'h1FF] = 16'h5550;
        step();
        rst = 1'b0;
        step();
        chk("wr.hi.pc", bus.pc, 32'hFFFF_0000);
        step();
        chk("wr.pc",   bus.pc, 32'hFFFF_FFFF);
        chk("wr.addr", bus.imem_addr, 32'hFFFF_FFFF);
        chk("wr.valid", {31'h0, bus.if_id_valid}, 32'h0);
        step();
        chk_ifid("wrap", 16'h5550, 16'h0, 32'h0, 1'b1);
        chk("wrap.pc", bus.pc, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
